// File: rtl/dcache_flush_arbiter.sv
// dcache_flush_arbiter: coalesces flush requests from several sources onto the single dcache flush port.
// Ports: clk_i/rst_ni clock and async active-low reset; req_i/ack_o/err_o per-requester handshake;
// flush_dcache_o/flush_dcache_ack_i dcache flush port; cache_busy_i dcache outstanding traffic;
// timeout_cycles_i FLUSH cycle limit (0 = none); busy_o/served_mask_o/flush_cnt_o status.
module dcache_flush_arbiter #(
  parameter int NR_REQ    = 3,
  parameter int TIMEOUT_W = 16,
  parameter int CNT_W     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NR_REQ-1:0]    req_i,
  output logic [NR_REQ-1:0]    ack_o,
  output logic                 err_o,
  output logic                 flush_dcache_o,
  input  logic                 flush_dcache_ack_i,
  input  logic                 cache_busy_i,
  input  logic [TIMEOUT_W-1:0] timeout_cycles_i,
  output logic                 busy_o,
  output logic [NR_REQ-1:0]    served_mask_o,
  output logic [CNT_W-1:0]     flush_cnt_o
);
  typedef enum logic [1:0] {S_IDLE, S_QUIESCE, S_FLUSH, S_RESP} state_e;
  state_e                state_q, state_d;
  logic [NR_REQ-1:0]    served_q, served_d, ack_q, ack_d, ack_prev_q, elig;
  logic [TIMEOUT_W-1:0] tcnt_q, tcnt_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d, flush_q, tmo;
  // ack_prev_q masks a requester still dropping its request right after its ack
  assign elig = req_i & ~ack_prev_q;
  // >= keeps the timeout effective if timeout_cycles_i is lowered below the running count
  assign tmo = (timeout_cycles_i != '0) && (tcnt_q >= timeout_cycles_i - TIMEOUT_W'(1));
  always_comb begin
    state_d  = state_q;
    served_d = served_q;
    case (state_q)
      S_IDLE: begin
        state_d  = |elig ? S_QUIESCE : S_IDLE;
        served_d = |elig ? elig : served_q;
      end
      S_QUIESCE: state_d = cache_busy_i ? S_QUIESCE : S_FLUSH;
      S_FLUSH:   state_d = (flush_dcache_ack_i || tmo) ? S_RESP : S_FLUSH;
      S_RESP: begin
        state_d  = S_IDLE;
        served_d = '0;
      end
      default: begin
        state_d  = S_IDLE;
        served_d = '0;
      end
    endcase
  end
  always_comb begin
    tcnt_d = (state_q == S_FLUSH) ? tcnt_q + TIMEOUT_W'(1) : '0;
    // acknowledge wins over a coincident timeout
    err_d  = (state_q == S_FLUSH) && !flush_dcache_ack_i && tmo;
    ack_d  = (state_d == S_RESP) ? served_d : '0;
    cnt_d  = ((state_q == S_FLUSH) && flush_dcache_ack_i && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      served_q   <= '0;
      ack_q      <= '0;
      ack_prev_q <= '0;
      err_q      <= 1'b0;
      flush_q    <= 1'b0;
      tcnt_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      served_q   <= served_d;
      ack_q      <= ack_d;
      ack_prev_q <= ack_q;
      err_q      <= err_d;
      flush_q    <= (state_d == S_FLUSH);
      tcnt_q     <= tcnt_d;
      cnt_q      <= cnt_d;
    end
  end
  assign ack_o          = ack_q;
  assign err_o          = err_q;
  assign flush_dcache_o = flush_q;
  assign busy_o         = (state_q != S_IDLE);
  assign served_mask_o  = served_q;
  assign flush_cnt_o    = cnt_q;
endmodule

// File: tb/tb_dcache_flush_arbiter.sv
// tb_dcache_flush_arbiter: directed self-checking bench for dcache_flush_arbiter.
module tb_dcache_flush_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [2:0]  req_i = '0;
  logic [2:0]  ack_o;
  logic        err_o;
  logic        flush_dcache_o;
  logic        flush_dcache_ack_i = 1'b0;
  logic        cache_busy_i = 1'b0;
  logic [15:0] timeout_cycles_i = '0;
  logic        busy_o;
  logic [2:0]  served_mask_o;
  logic [15:0] flush_cnt_o;
  int vectors = 0;
  int miscompares = 0;
  dcache_flush_arbiter #(.NR_REQ(3), .TIMEOUT_W(16), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .ack_o(ack_o), .err_o(err_o),
    .flush_dcache_o(flush_dcache_o), .flush_dcache_ack_i(flush_dcache_ack_i),
    .cache_busy_i(cache_busy_i), .timeout_cycles_i(timeout_cycles_i), .busy_o(busy_o),
    .served_mask_o(served_mask_o), .flush_cnt_o(flush_cnt_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic do_reset();
    rst_ni = 1'b0;
    req_i = '0;
    flush_dcache_ack_i = 1'b0;
    cache_busy_i = 1'b0;
    timeout_cycles_i = '0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask
  // Runs until an ack_o pulse (bounded). Drives the dcache ack in FLUSH cycle index ack_idx
  // (-1 = never) and ORs add_req into req_i in the first FLUSH cycle.
  task automatic run_round(input int ack_idx, input logic [2:0] add_req, output int hi,
                           output logic [2:0] am, output logic e, output int lat);
    hi = 0; lat = 0; am = '0; e = 1'b0;
    while (lat < 300) begin
      if (flush_dcache_o) begin
        if (hi == 0) req_i = req_i | add_req;
        flush_dcache_ack_i = (hi == ack_idx);
        hi++;
      end else flush_dcache_ack_i = 1'b0;
      tick();
      lat++;
      if (ack_o != '0) begin
        am = ack_o;
        e = err_o;
        break;
      end
    end
    flush_dcache_ack_i = 1'b0;
  endtask
  task automatic test_reset();
    rst_ni = 1'b0;
    #1;
    vectors++;
    if ({ack_o, err_o, flush_dcache_o, busy_o, served_mask_o, flush_cnt_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got ack=%b err=%b flush=%b busy=%b mask=%b cnt=%0d want all 0",
               ack_o, err_o, flush_dcache_o, busy_o, served_mask_o, flush_cnt_o);
    end
    do_reset();
    flush_dcache_ack_i = 1'b1;
    tick();
    flush_dcache_ack_i = 1'b0;
    tick();
    vectors++;
    if ({busy_o, ack_o, flush_cnt_o} !== '0) begin
      miscompares++;
      $display("FAIL stray_ack_ignored: got busy=%b ack=%b cnt=%0d want 0 0 0", busy_o, ack_o, flush_cnt_o);
    end
  endtask
  task automatic test_single();
    int hi, lat;
    logic [2:0] am;
    logic e;
    do_reset();
    req_i = 3'b001;
    run_round(5, 3'b000, hi, am, e, lat);
    vectors++;
    if (hi !== 6) begin miscompares++; $display("FAIL single_flush_len: got %0d want 6", hi); end
    vectors++;
    if (lat !== 8) begin miscompares++; $display("FAIL single_latency: got %0d want 8", lat); end
    vectors++;
    if ({am, e} !== {3'b001, 1'b0}) begin
      miscompares++; $display("FAIL single_ack: got ack=%b err=%b want 001 0", am, e);
    end
    vectors++;
    if (flush_cnt_o !== 16'd1) begin miscompares++; $display("FAIL single_cnt: got %0d want 1", flush_cnt_o); end
    tick();
    vectors++;
    if ({ack_o, busy_o, flush_dcache_o} !== 5'b0) begin
      miscompares++; $display("FAIL single_after: got ack=%b busy=%b flush=%b want 000 0 0", ack_o, busy_o, flush_dcache_o);
    end
    req_i = '0;
    tick();
    vectors++;
    if ({busy_o, flush_cnt_o} !== {1'b0, 16'd1}) begin
      miscompares++; $display("FAIL single_no_refire: got busy=%b cnt=%0d want 0 1", busy_o, flush_cnt_o);
    end
  endtask
  task automatic test_coalesce();
    int hi, lat;
    logic [2:0] am;
    logic e;
    do_reset();
    req_i = 3'b101;
    run_round(2, 3'b010, hi, am, e, lat);
    vectors++;
    if ({am, served_mask_o} !== {3'b101, 3'b101}) begin
      miscompares++; $display("FAIL coalesce_first: got ack=%b mask=%b want 101 101", am, served_mask_o);
    end
    tick();
    vectors++;
    if (busy_o !== 1'b0) begin miscompares++; $display("FAIL coalesce_idle_gap: got busy=%b want 0", busy_o); end
    req_i = 3'b010;
    tick();
    vectors++;
    if ({busy_o, served_mask_o} !== {1'b1, 3'b010}) begin
      miscompares++; $display("FAIL coalesce_second_capture: got busy=%b mask=%b want 1 010", busy_o, served_mask_o);
    end
    run_round(0, 3'b000, hi, am, e, lat);
    vectors++;
    if ({am, e} !== {3'b010, 1'b0}) begin
      miscompares++; $display("FAIL coalesce_second_ack: got ack=%b err=%b want 010 0", am, e);
    end
    vectors++;
    if (flush_cnt_o !== 16'd2) begin miscompares++; $display("FAIL coalesce_cnt: got %0d want 2", flush_cnt_o); end
    req_i = '0;
    tick();
  endtask
  task automatic test_quiesce();
    int hi, lat, early;
    logic [2:0] am;
    logic e;
    do_reset();
    req_i = 3'b100;
    cache_busy_i = 1'b1;
    early = 0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 7) cache_busy_i = 1'b0;
      if (flush_dcache_o) early++;
    end
    vectors++;
    if (early !== 0) begin miscompares++; $display("FAIL quiesce_hold: got %0d early flush cycles want 0", early); end
    tick();
    vectors++;
    if (flush_dcache_o !== 1'b1) begin miscompares++; $display("FAIL quiesce_release: got flush=%b want 1", flush_dcache_o); end
    run_round(0, 3'b000, hi, am, e, lat);
    vectors++;
    if ({am, e} !== {3'b100, 1'b0}) begin
      miscompares++; $display("FAIL quiesce_ack: got ack=%b err=%b want 100 0", am, e);
    end
    req_i = '0;
    tick();
  endtask
  task automatic test_timeout();
    int hi, lat;
    logic [2:0] am;
    logic e;
    do_reset();
    timeout_cycles_i = 16'd10;
    req_i = 3'b001;
    run_round(-1, 3'b000, hi, am, e, lat);
    vectors++;
    if (hi !== 10) begin miscompares++; $display("FAIL timeout_len: got %0d want 10", hi); end
    vectors++;
    if ({am, e} !== {3'b001, 1'b1}) begin
      miscompares++; $display("FAIL timeout_ack: got ack=%b err=%b want 001 1", am, e);
    end
    vectors++;
    if (flush_cnt_o !== 16'd0) begin miscompares++; $display("FAIL timeout_cnt: got %0d want 0", flush_cnt_o); end
    req_i = '0;
    tick();
    vectors++;
    if ({err_o, ack_o} !== 4'b0) begin
      miscompares++; $display("FAIL timeout_pulse_end: got err=%b ack=%b want 0 000", err_o, ack_o);
    end
  endtask
  task automatic test_ack_vs_timeout();
    int hi, lat;
    logic [2:0] am;
    logic e;
    do_reset();
    timeout_cycles_i = 16'd4;
    req_i = 3'b010;
    run_round(3, 3'b000, hi, am, e, lat);
    vectors++;
    if ({hi, am, e} !== {32'd4, 3'b010, 1'b0}) begin
      miscompares++; $display("FAIL tie_ack_wins: got len=%0d ack=%b err=%b want 4 010 0", hi, am, e);
    end
    vectors++;
    if (flush_cnt_o !== 16'd1) begin miscompares++; $display("FAIL tie_cnt: got %0d want 1", flush_cnt_o); end
    req_i = '0;
    tick();
  endtask
  task automatic test_reset_mid_flush();
    int hi, lat, pulses;
    logic [2:0] am;
    logic e;
    do_reset();
    req_i = 3'b001;
    tick();
    tick();
    tick();
    tick();
    rst_ni = 1'b0;
    #1;
    vectors++;
    if ({ack_o, err_o, flush_dcache_o, busy_o, served_mask_o, flush_cnt_o} !== '0) begin
      miscompares++;
      $display("FAIL midreset_async: got ack=%b err=%b flush=%b busy=%b mask=%b cnt=%0d want all 0",
               ack_o, err_o, flush_dcache_o, busy_o, served_mask_o, flush_cnt_o);
    end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ack_o != '0) pulses++;
    end
    rst_ni = 1'b1;
    tick();
    if (ack_o != '0) pulses++;
    vectors++;
    if (pulses !== 0) begin miscompares++; $display("FAIL midreset_no_ack: got %0d ack cycles want 0", pulses); end
    vectors++;
    if ({busy_o, flush_dcache_o, served_mask_o} !== {1'b1, 1'b0, 3'b001}) begin
      miscompares++;
      $display("FAIL midreset_requiesce: got busy=%b flush=%b mask=%b want 1 0 001", busy_o, flush_dcache_o, served_mask_o);
    end
    run_round(0, 3'b000, hi, am, e, lat);
    vectors++;
    if ({am, e, flush_cnt_o} !== {3'b001, 1'b0, 16'd1}) begin
      miscompares++; $display("FAIL midreset_round: got ack=%b err=%b cnt=%0d want 001 0 1", am, e, flush_cnt_o);
    end
    req_i = '0;
    tick();
  endtask
  initial begin
    test_reset();
    test_single();
    test_coalesce();
    test_quiesce();
    test_timeout();
    test_ack_vs_timeout();
    test_reset_mid_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
